// File: rtl/regfile_wr_sched.sv
// Write-port scheduler for the 16x16 register file.
// Round-robin ALU/load writeback plus an init sweep.
module regfile_wr_sched #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 4,
  parameter int unsigned NREG = 16,
  parameter logic [DW-1:0] INIT_VALUE = '0
) (
  input  logic          Clk,
  input  logic          Clear_n,
  input  logic          init_req,
  output logic          init_busy,
  output logic          init_done,
  input  logic          w0_valid,
  output logic          w0_ready,
  input  logic [AW-1:0] w0_addr,
  input  logic [DW-1:0] w0_data,
  input  logic          w1_valid,
  output logic          w1_ready,
  input  logic [AW-1:0] w1_addr,
  input  logic [DW-1:0] w1_data,
  output logic          rf_load,
  output logic [AW-1:0] rf_caddr,
  output logic [DW-1:0] rf_c,
  output logic          last_gnt
);

  typedef enum logic {
    RUN  = 1'b0,
    INIT = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  state_t        state;
  logic [AW-1:0] cnt;
  logic          arb;
  logic          pick0;
  logic          pick1;

  // Requester 0 wins unless 1 is the only one or it is 1's turn.
  assign arb   = Clear_n & (state == RUN) & ~init_req;
  assign pick0 = w0_valid & (~w1_valid | last_gnt);
  assign pick1 = w1_valid & (~w0_valid | ~last_gnt);
  assign w0_ready = arb & pick0;
  assign w1_ready = arb & pick1;

  // Register the winning write or the next init write.
  always_ff @(posedge Clk or negedge Clear_n) begin
    if (!Clear_n) begin
      state     <= RUN;
      cnt       <= '0;
      last_gnt  <= 1'b1;
      rf_load   <= 1'b0;
      rf_caddr  <= '0;
      rf_c      <= '0;
      init_busy <= 1'b0;
      init_done <= 1'b0;
    end else begin
      rf_load   <= 1'b0;
      init_done <= 1'b0;
      case (state)
        RUN: begin
          if (init_req) begin
            state     <= INIT;
            init_busy <= 1'b1;
          end else if (w0_ready) begin
            rf_load  <= 1'b1;
            rf_caddr <= w0_addr;
            rf_c     <= w0_data;
            last_gnt <= 1'b0;
          end else if (w1_ready) begin
            rf_load  <= 1'b1;
            rf_caddr <= w1_addr;
            rf_c     <= w1_data;
            last_gnt <= 1'b1;
          end
        end
        INIT: begin
          rf_load  <= 1'b1;
          rf_caddr <= cnt;
          rf_c     <= INIT_VALUE;
          cnt      <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= RUN;
            init_busy <= 1'b0;
            init_done <= 1'b1;
          end
        end
        default: begin
          state     <= RUN;
          cnt       <= '0;
          init_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Bench for regfile_wr_sched: scoreboard against a
// behavioural arbiter/sweep model with random traffic.
module tb_regfile_wr_sched;

  localparam int NREG = 16;
  localparam logic [15:0] IV = 16'h0000;

  logic        Clk = 1'b0;
  logic        Clear_n = 1'b1;
  logic        init_req = 1'b0;
  logic        w0_valid = 1'b0;
  logic        w1_valid = 1'b0;
  logic [3:0]  w0_addr = '0;
  logic [3:0]  w1_addr = '0;
  logic [15:0] w0_data = '0;
  logic [15:0] w1_data = '0;
  logic        init_busy, init_done;
  logic        w0_ready, w1_ready;
  logic        rf_load, last_gnt;
  logic [3:0]  rf_caddr;
  logic [15:0] rf_c;

  regfile_wr_sched #(
    .DW(16), .AW(4), .NREG(16), .INIT_VALUE(IV)
  ) dut (
    .Clk(Clk), .Clear_n(Clear_n),
    .init_req(init_req),
    .init_busy(init_busy), .init_done(init_done),
    .w0_valid(w0_valid), .w0_ready(w0_ready),
    .w0_addr(w0_addr), .w0_data(w0_data),
    .w1_valid(w1_valid), .w1_ready(w1_ready),
    .w1_addr(w1_addr), .w1_data(w1_data),
    .rf_load(rf_load), .rf_caddr(rf_caddr),
    .rf_c(rf_c), .last_gnt(last_gnt)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [3:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t expq[$];
  int errors = 0;
  int checks = 0;
  logic [15:0] mmem [16];
  logic [15:0] dmem [16];

  bit  m_init;
  int  m_cnt;
  bit  m_last;
  bit  m_done_next;
  bit  pend;
  wr_t pend_w;
  bit  t0, t1;
  wr_t mw;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_init = 0;
    m_cnt = 0;
    m_last = 1;
    m_done_next = 0;
    pend = 0;
    expq.delete();
  endtask

  // One cycle: model evaluates at negedge, inputs change at posedge+1.
  task automatic step();
    bit e0, e1;
    wr_t w;
    @(negedge Clk);
    if (pend) mmem[pend_w.a] = pend_w.d;
    pend = 0;
    chk("init_busy", init_busy, m_init);
    chk("init_done", init_done, m_done_next);
    chk("last_gnt", last_gnt, m_last);
    m_done_next = 0;
    e0 = 0;
    e1 = 0;
    if (m_init) begin
      w.a = 4'(m_cnt);
      w.d = IV;
      expq.push_back(w);
      pend = 1;
      pend_w = w;
      if (m_cnt == NREG - 1) begin
        m_init = 0;
        m_cnt = 0;
        m_done_next = 1;
      end else begin
        m_cnt++;
      end
    end else if (init_req) begin
      m_init = 1;
    end else if (w0_valid && w1_valid) begin
      if (m_last) e0 = 1;
      else e1 = 1;
    end else begin
      e0 = w0_valid;
      e1 = w1_valid;
    end
    chk("ready", {w1_ready, w0_ready}, {e1, e0});
    if (e0) begin
      w.a = w0_addr;
      w.d = w0_data;
      expq.push_back(w);
      pend = 1;
      pend_w = w;
      m_last = 0;
    end
    if (e1) begin
      w.a = w1_addr;
      w.d = w1_data;
      expq.push_back(w);
      pend = 1;
      pend_w = w;
      m_last = 1;
    end
    t0 = e0;
    t1 = e1;
    @(posedge Clk);
    #1;
  endtask

  task automatic post();
    if (t0) w0_valid = 0;
    if (t1) w1_valid = 0;
  endtask

  task automatic do_reset();
    Clear_n = 0;
    #1;
    chk("rst rf_load", rf_load, 0);
    chk("rst init_busy", init_busy, 0);
    chk("rst init_done", init_done, 0);
    chk("rst w0_ready", w0_ready, 0);
    chk("rst w1_ready", w1_ready, 0);
    chk("rst last_gnt", last_gnt, 1);
    model_reset();
    t0 = 0;
    t1 = 0;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Clear_n = 1;
  endtask

  task automatic drain();
    init_req = 0;
    for (int k = 0; k < 40 && (w0_valid || w1_valid); k++) begin
      step();
      post();
    end
    chk("drain", {w1_valid, w0_valid}, 0);
  endtask

  // Scoreboard monitor: every rf_load must match the oldest expected write.
  always @(negedge Clk) begin
    if (Clear_n === 1'b1 && rf_load === 1'b1) begin
      dmem[rf_caddr] = rf_c;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_load: got addr %0h data %0h want none",
                 rf_caddr, rf_c);
      end else begin
        mw = expq.pop_front();
        chk("rf_caddr", rf_caddr, mw.a);
        chk("rf_c", rf_c, mw.d);
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      mmem[i] = 16'hDEAD;
      dmem[i] = 16'hDEAD;
    end
    w0_valid = 1;
    w1_valid = 1;
    #2;
    do_reset();
    chk("rst rf_caddr", rf_caddr, 0);
    chk("rst rf_c", rf_c, 0);
    w0_valid = 0;
    w1_valid = 0;

    // single write from requester 0
    w0_valid = 1;
    w0_addr = 3;
    w0_data = 16'hBEEF;
    step();
    post();
    step();
    step();

    // both held: alternating grants after reset
    do_reset();
    w0_valid = 1;
    w0_addr = 1;
    w0_data = 16'hA001;
    w1_valid = 1;
    w1_addr = 2;
    w1_data = 16'hB001;
    for (int i = 0; i < 4; i++) begin
      step();
      if (t0) begin
        w0_addr = 4'(i + 4);
        w0_data = 16'hA100 + 16'(i);
      end
      if (t1) begin
        w1_addr = 4'(i + 8);
        w1_data = 16'hB100 + 16'(i);
      end
    end
    drain();

    // same address, tie after reset
    do_reset();
    w0_valid = 1;
    w0_addr = 5;
    w0_data = 16'h1111;
    w1_valid = 1;
    w1_addr = 5;
    w1_data = 16'h2222;
    step();
    post();
    step();
    post();
    step();
    step();
    chk("R5 later wins", dmem[5], 16'h2222);

    // init sweep with requester 1 waiting
    init_req = 1;
    w1_valid = 1;
    w1_addr = 9;
    w1_data = 16'h5A5A;
    step();
    init_req = 0;
    for (int i = 0; i < 16; i++) step();
    step();
    post();
    step();
    step();
    chk("R9 after sweep", dmem[9], 16'h5A5A);
    chk("R0 after sweep", dmem[0], IV);

    // reset in the middle of a sweep, then restart
    init_req = 1;
    step();
    init_req = 0;
    for (int i = 0; i < 7; i++) step();
    do_reset();
    init_req = 1;
    step();
    init_req = 0;
    for (int i = 0; i < 18; i++) step();

    // requester 1 alone, back-to-back
    for (int i = 0; i < 8; i++) begin
      w1_valid = 1;
      w1_addr = 4'(i);
      w1_data = 16'($urandom);
      step();
      chk("b2b grant", t1, 1);
    end
    w1_valid = 0;
    step();
    chk("b2b last_gnt", last_gnt, 1);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      step();
      if (!w0_valid || t0) begin
        w0_valid = ($urandom_range(0, 2) != 0);
        w0_addr = 4'($urandom);
        w0_data = 16'($urandom);
      end
      if (!w1_valid || t1) begin
        w1_valid = ($urandom_range(0, 2) != 0);
        w1_addr = 4'($urandom);
        w1_data = 16'($urandom);
      end
      init_req = ($urandom_range(0, 59) == 0);
      if (n == 300) do_reset();
    end
    drain();
    for (int i = 0; i < 3; i++) step();
    chk("queue empty", expq.size(), 0);
    for (int i = 0; i < 16; i++) chk("regfile", dmem[i], mmem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
